// File: rtl/cpu_control_unit_if.sv
// Control-unit bus: instruction handshake in, datapath controls out.
//   master : the control unit (drives handshake ready and all controls)
//   slave  : fetch/datapath side (drives instruction, valid, zero, busywait)
// Signals: instruction[31:0], instr_valid, instr_ready, zero, busywait,
//   aluop[3:0], neg_sel, imm_sel, reg_write_en, wb_sel, mem_read, mem_write,
//   pc_sel, illegal, mem_error, instr_count[CNT_W-1:0].
interface cpu_control_unit_if #(parameter int CNT_W = 16);
  logic [31:0]      instruction;
  logic             instr_valid;
  logic             instr_ready;
  logic             zero;
  logic             busywait;
  logic [3:0]       aluop;
  logic             neg_sel;
  logic             imm_sel;
  logic             reg_write_en;
  logic             wb_sel;
  logic             mem_read;
  logic             mem_write;
  logic             pc_sel;
  logic             illegal;
  logic             mem_error;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  instruction, instr_valid, zero, busywait,
    output instr_ready, aluop, neg_sel, imm_sel, reg_write_en, wb_sel,
           mem_read, mem_write, pc_sel, illegal, mem_error, instr_count
  );

  modport slave (
    output instruction, instr_valid, zero, busywait,
    input  instr_ready, aluop, neg_sel, imm_sel, reg_write_en, wb_sel,
           mem_read, mem_write, pc_sel, illegal, mem_error, instr_count
  );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit for the 8-bit processor: IDLE -> EXEC -> (MEM -> (WB)).
// Ports: clk, rst_n (async, active low), bus (cpu_control_unit_if.master).
// All controls are registered; only instr_ready and pc_sel are combinational
// (pc_sel must follow the ALU zero flag produced during the EXEC cycle).
module cpu_control_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cpu_control_unit_if.master bus
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

  typedef struct packed {
    logic [3:0] aluop;
    logic       neg, imm, wr, jmp, beq, bne, ld, st, ill;
  } dec_t;

  function automatic dec_t decode(input logic [7:0] op);
    dec_t d;
    d = '0;
    case (op)
      8'h00: begin d.imm = 1'b1; d.wr = 1'b1; end
      8'h01: d.wr = 1'b1;
      8'h02: begin d.aluop = 4'h1; d.wr = 1'b1; end
      8'h03: begin d.aluop = 4'h1; d.neg = 1'b1; d.wr = 1'b1; end
      8'h04: begin d.aluop = 4'h2; d.wr = 1'b1; end
      8'h05: begin d.aluop = 4'h3; d.wr = 1'b1; end
      8'h0C: begin d.aluop = 4'h4; d.wr = 1'b1; end
      8'h0D: begin d.aluop = 4'h5; d.imm = 1'b1; d.wr = 1'b1; end
      8'h0E: begin d.aluop = 4'h6; d.imm = 1'b1; d.wr = 1'b1; end
      8'h0F: begin d.aluop = 4'h7; d.imm = 1'b1; d.wr = 1'b1; end
      8'h10: begin d.aluop = 4'h8; d.imm = 1'b1; d.wr = 1'b1; end
      8'h06: d.jmp = 1'b1;
      8'h07: begin d.aluop = 4'h1; d.neg = 1'b1; d.beq = 1'b1; end
      8'h11: begin d.aluop = 4'h1; d.neg = 1'b1; d.bne = 1'b1; end
      8'h08: d.ld = 1'b1;
      8'h09: begin d.ld = 1'b1; d.imm = 1'b1; end
      8'h0A: d.st = 1'b1;
      8'h0B: begin d.st = 1'b1; d.imm = 1'b1; end
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

  state_t            state;
  dec_t              dec;
  logic [3:0]        aluop_q;
  logic              neg_q, imm_q, wr_q, wb_q, mrd_q, mwr_q;
  logic              jmp_q, beq_q, bne_q, ill_q, err_q, ld_q, st_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  cnt_q;

  // Only the opcode byte steers control; operand fields go to the datapath.
  logic unused_operands;
  assign unused_operands = ^bus.instruction[23:0];

  assign dec = decode(bus.instruction[31:24]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      aluop_q <= '0;
      neg_q   <= 1'b0;
      imm_q   <= 1'b0;
      wr_q    <= 1'b0;
      wb_q    <= 1'b0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      jmp_q   <= 1'b0;
      beq_q   <= 1'b0;
      bne_q   <= 1'b0;
      ill_q   <= 1'b0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: if (bus.instr_valid) begin
          // Load the EXEC-cycle controls so they are live from the first EXEC edge.
          state   <= EXEC;
          aluop_q <= dec.aluop;
          neg_q   <= dec.neg;
          imm_q   <= dec.imm;
          wr_q    <= dec.wr;
          jmp_q   <= dec.jmp;
          beq_q   <= dec.beq;
          bne_q   <= dec.bne;
          ill_q   <= dec.ill;
          ld_q    <= dec.ld;
          st_q    <= dec.st;
        end
        EXEC: begin
          neg_q  <= 1'b0;
          wr_q   <= 1'b0;
          jmp_q  <= 1'b0;
          beq_q  <= 1'b0;
          bne_q  <= 1'b0;
          ill_q  <= 1'b0;
          wait_q <= '0;
          if (ld_q || st_q) begin
            // aluop/imm stay put: the address keeps flowing through MEM.
            state <= MEM;
            mrd_q <= ld_q;
            mwr_q <= st_q;
          end else begin
            state   <= IDLE;
            aluop_q <= '0;
            imm_q   <= 1'b0;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        MEM: begin
          if (!bus.busywait) begin
            state   <= ld_q ? WB : IDLE;
            wr_q    <= ld_q;
            wb_q    <= ld_q;
            if (st_q) cnt_q <= cnt_q + CNT_W'(1);
          end else if (wait_q == WAIT_LAST) begin
            // Abort: this busy cycle is the MEM_TIMEOUT-th one; no retirement.
            state <= IDLE;
            err_q <= 1'b0 | 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
          if (!bus.busywait || wait_q == WAIT_LAST) begin
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            aluop_q <= '0;
            imm_q   <= 1'b0;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            wait_q  <= '0;
          end
        end
        WB: begin
          state <= IDLE;
          wr_q  <= 1'b0;
          wb_q  <= 1'b0;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ready is masked by reset so every output reads 0 while reset is held.
  assign bus.instr_ready  = rst_n && (state == IDLE);
  assign bus.aluop        = aluop_q;
  assign bus.neg_sel      = neg_q;
  assign bus.imm_sel      = imm_q;
  assign bus.reg_write_en = wr_q;
  assign bus.wb_sel       = wb_q;
  assign bus.mem_read     = mrd_q;
  assign bus.mem_write    = mwr_q;
  assign bus.pc_sel       = jmp_q | (beq_q & bus.zero) | (bne_q & ~bus.zero);
  assign bus.illegal      = ill_q;
  assign bus.mem_error    = err_q;
  assign bus.instr_count  = cnt_q;
endmodule

// File: tb/tb_cpu_control_unit.sv
module tb_cpu_control_unit;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_control_unit_if #(.CNT_W(CW)) bus();
  cpu_control_unit #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [3:0] aluop;
    logic neg, imm, wr, wb, mr, mw, pc, ill, err, rdy;
  } ctl_t;

  typedef struct packed {
    logic [7:0] op;
    logic       zero;
    ctl_t       exp;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  ctl_t sb[$];
  logic acc = 1'b0;

  function automatic ctl_t mk(input logic [3:0] a, input logic n, input logic i,
                              input logic w, input logic p, input logic il);
    ctl_t c;
    c = '0;
    c.aluop = a; c.neg = n; c.imm = i; c.wr = w; c.pc = p; c.ill = il;
    return c;
  endfunction

  function automatic ctl_t cur();
    return {bus.aluop, bus.neg_sel, bus.imm_sel, bus.reg_write_en, bus.wb_sel,
            bus.mem_read, bus.mem_write, bus.pc_sel, bus.illegal, bus.mem_error,
            bus.instr_ready};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: an accepted instruction's EXEC cycle is the negedge after acceptance.
  always @(posedge clk) acc <= rst_n && bus.instr_valid && bus.instr_ready;
  always @(negedge clk) begin
    if (acc) begin
      if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else check("exec_ctl", 32'(cur()), 32'(sb.pop_front()));
    end
  end

  task automatic send(input logic [7:0] op, input logic z, input ctl_t e);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.instr_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.instr_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.instruction = {op, 24'h112233};
    bus.zero        = z;
    bus.instr_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instruction = 32'hDEADBEEF;  // must be ignored outside IDLE
  endtask

  vec_t tbl[$];
  ctl_t c;
  logic [CW-1:0] cnt0;

  initial begin
    bus.instruction = '0;
    bus.instr_valid = 1'b0;
    bus.zero        = 1'b0;
    bus.busywait    = 1'b0;

    tbl.push_back('{8'h02, 1'b0, mk(4'h1, 0, 0, 1, 0, 0)});  // add
    tbl.push_back('{8'h0D, 1'b0, mk(4'h5, 0, 1, 1, 0, 0)});  // sll
    tbl.push_back('{8'h10, 1'b0, mk(4'h8, 0, 1, 1, 0, 0)});  // ror
    tbl.push_back('{8'h00, 1'b0, mk(4'h0, 0, 1, 1, 0, 0)});  // loadi
    tbl.push_back('{8'h01, 1'b0, mk(4'h0, 0, 0, 1, 0, 0)});  // mov
    tbl.push_back('{8'h03, 1'b0, mk(4'h1, 1, 0, 1, 0, 0)});  // sub
    tbl.push_back('{8'h04, 1'b0, mk(4'h2, 0, 0, 1, 0, 0)});  // and
    tbl.push_back('{8'h05, 1'b0, mk(4'h3, 0, 0, 1, 0, 0)});  // or
    tbl.push_back('{8'h0C, 1'b0, mk(4'h4, 0, 0, 1, 0, 0)});  // mult
    tbl.push_back('{8'h0E, 1'b0, mk(4'h6, 0, 1, 1, 0, 0)});  // srl
    tbl.push_back('{8'h0F, 1'b0, mk(4'h7, 0, 1, 1, 0, 0)});  // sra
    tbl.push_back('{8'h06, 1'b0, mk(4'h0, 0, 0, 0, 1, 0)});  // j
    tbl.push_back('{8'h07, 1'b1, mk(4'h1, 1, 0, 0, 1, 0)});  // beq taken
    tbl.push_back('{8'h11, 1'b1, mk(4'h1, 1, 0, 0, 0, 0)});  // bne not taken
    tbl.push_back('{8'h07, 1'b0, mk(4'h1, 1, 0, 0, 0, 0)});  // beq not taken
    tbl.push_back('{8'h11, 1'b0, mk(4'h1, 1, 0, 0, 1, 0)});  // bne taken
    tbl.push_back('{8'hFF, 1'b0, mk(4'h0, 0, 0, 0, 0, 1)});  // illegal

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ctl", 32'(cur()), 32'd0);
    check("reset_cnt", 32'(bus.instr_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.instr_ready), 32'd1);

    // First add, then the rest of the table back to back
    send(tbl[0].op, tbl[0].zero, tbl[0].exp);
    @(negedge clk);
    @(negedge clk);
    check("cnt_after_add", 32'(bus.instr_count), 32'd1);
    for (int i = 1; i < tbl.size(); i++) send(tbl[i].op, tbl[i].zero, tbl[i].exp);
    @(negedge clk);
    @(negedge clk);
    check("ill_one_cycle", 32'(bus.illegal), 32'd0);
    check("cnt_after_table", 32'(bus.instr_count), 32'(tbl.size()));

    // lwd with BUSYWAIT high for 3 MEM cycles: 4 MEM cycles, then WB
    cnt0 = bus.instr_count;
    send(8'h08, 1'b0, mk(4'h0, 0, 0, 0, 0, 0));
    @(negedge clk);  // EXEC
    bus.busywait = 1'b1;
    c = '0; c.mr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("lwd_mem%0d", i), 32'(cur()), 32'(c));
      if (i == 3) bus.busywait = 1'b0;
      else if (i == 2) bus.busywait = 1'b0 | 1'b1;
    end
    @(negedge clk);
    c = '0; c.wr = 1'b1; c.wb = 1'b1;
    check("lwd_wb", 32'(cur()), 32'(c));
    check("lwd_cnt_not_yet", 32'(bus.instr_count), 32'(cnt0));
    @(negedge clk);
    check("lwd_cnt", 32'(bus.instr_count), 32'(cnt0 + 8'd1));

    // swd with no wait: one MEM cycle, retires on the MEM exit edge
    send(8'h0A, 1'b0, mk(4'h0, 0, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    c = '0; c.mw = 1'b1;
    check("swd_mem", 32'(cur()), 32'(c));
    @(negedge clk);
    check("swd_idle", 32'(cur()), 32'(ctl_t'(1)));
    check("swd_cnt", 32'(bus.instr_count), 32'(cnt0 + 8'd2));

    // swi with BUSYWAIT stuck: timeout after 4 busy MEM cycles
    cnt0 = bus.instr_count;
    send(8'h0B, 1'b0, mk(4'h0, 0, 1, 0, 0, 0));
    @(negedge clk);
    bus.busywait = 1'b1;
    c = '0; c.mw = 1'b1; c.imm = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("swi_mem%0d", i), 32'(cur()), 32'(c));
    end
    @(negedge clk);
    c = '0; c.err = 1'b1; c.rdy = 1'b1;
    check("swi_timeout", 32'(cur()), 32'(c));
    check("swi_cnt", 32'(bus.instr_count), 32'(cnt0));
    @(negedge clk);
    check("swi_err_pulse", 32'(bus.mem_error), 32'd0);

    // Reset asserted mid-MEM drops the request immediately
    send(8'h09, 1'b0, mk(4'h0, 0, 1, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    check("lwi_mem_before_rst", 32'(bus.mem_read), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_ctl", 32'(cur()), 32'd0);
    check("rst_mid_mem_cnt", 32'(bus.instr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.busywait = 1'b0;

    // Counter wrap: 255 adds, then an illegal op wraps 0xFF -> 0x00
    for (int i = 0; i < 255; i++) send(8'h02, 1'b0, mk(4'h1, 0, 0, 1, 0, 0));
    @(negedge clk);
    @(negedge clk);
    check("cnt_ff", 32'(bus.instr_count), 32'hFF);
    send(8'hFF, 1'b0, mk(4'h0, 0, 0, 0, 0, 1));
    @(negedge clk);
    @(negedge clk);
    check("cnt_wrap", 32'(bus.instr_count), 32'h00);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
